// File: rtl/btn_sw_dev_io_pkg.sv
// Shared definitions for the switch/button input device: bus address, status-word
// layout and debounce defaults.
package btn_sw_dev_io_pkg;
  localparam logic [31:0] IO_ADDR       = 32'hffff_fe00;
  localparam int          SW_LSB        = 0;
  localparam int          BTN_LSB       = 8;
  localparam int          PEND_LSB      = 12;
  localparam int          NUM_SW        = 8;
  localparam int          NUM_BTN       = 4;
  localparam int          NUM_LANES     = NUM_SW + NUM_BTN;
  localparam int          DB_CYCLES_DEF = 500000;

  function automatic logic [31:0] pack_status(logic [NUM_SW-1:0] sw,
                                              logic [NUM_BTN-1:0] btn,
                                              logic [NUM_BTN-1:0] pend);
    logic [31:0] w;
    w                     = '0;
    w[SW_LSB+:NUM_SW]     = sw;
    w[BTN_LSB+:NUM_BTN]   = btn;
    w[PEND_LSB+:NUM_BTN]  = pend;
    return w;
  endfunction
endpackage

// File: rtl/btn_sw_dev_io_if.sv
// CPU-side read port of the input device: read strobe in, status word and irq out.
interface btn_sw_dev_io_if;
  logic        GPIOfffffe00_re;
  logic [31:0] peripheral_out;
  logic        irq;

  modport master (output GPIOfffffe00_re, input peripheral_out, input irq);
  modport slave  (input GPIOfffffe00_re, output peripheral_out, output irq);
endinterface

// File: rtl/btn_sw_dev_io_debounce_bit.sv
// One input lane: 2-flop synchronizer followed by a hold-time debounce counter.
module debounce_bit #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

  logic            s1, s2;
  logic [DB_W-1:0] cnt;

  // Counter only runs while the synchronized level disagrees with db, so any
  // return to the old level before LAST discards the partial count.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/btn_sw_dev_io.sv
// Switch/button input device: per-lane debounce, read-to-clear press flags,
// combinational status word and level irq.
module btn_sw_dev_io
  import btn_sw_dev_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = 20,
  parameter int IRQ_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SW-1:0]    sw_in,
  input  logic [NUM_BTN-1:0]   btn_in,
  btn_sw_dev_io_if.slave       bus
);
  logic [NUM_LANES-1:0] raw, db;
  logic [NUM_BTN-1:0]   btn_db_q, pend_q, rise, pending;

  assign raw = {btn_in, sw_in};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    debounce_bit #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .db    (db[i])
    );
  end

  // A rise is visible the same edge db goes high (db vs. its one-edge-old copy);
  // pend_q absorbs it on the following edge unless that edge is a read.
  assign rise    = db[NUM_LANES-1:NUM_SW] & ~btn_db_q;
  assign pending = pend_q | rise;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      btn_db_q <= '0;
      pend_q   <= '0;
    end else begin
      btn_db_q <= db[NUM_LANES-1:NUM_SW];
      pend_q   <= bus.GPIOfffffe00_re ? '0 : pending;
    end
  end

  assign bus.peripheral_out = pack_status(db[NUM_SW-1:0], db[NUM_LANES-1:NUM_SW], pending);
  assign bus.irq            = (IRQ_EN != 0) && (|pending);
endmodule

// File: doc/btn_sw_dev_io.md
Name: btn_sw_dev_io

Overview:
- Input-side GPIO peripheral. It is the CPU-read counterpart of the memory-mapped LED/counter output device.
- Synchronizes and debounces 8 board switches and 4 push-buttons.
- Latches button-press events into read-to-clear pending flags, presents a 32-bit status word to the CPU read mux for address 0xfffffe00, and raises a level interrupt request while any press is pending.

Parameters:
- DB_CYCLES, 500000, clocks an input must hold a new value before the debounced value changes (minimum 2).
- DB_W, 20, debounce counter width; must satisfy 2^DB_W > DB_CYCLES.
- IRQ_EN, 1, 1 = irq driven from pending flags; 0 = irq tied low.

Ports:
- clk  input  1  system clock; all flops update on negedge clk, matching the peripheral bus timing.
- reset  input  1  reset, asynchronous, active-high.
- GPIOfffffe00_re  input  1  CPU read strobe for this device, sampled on negedge clk.
- sw_in  input  8  raw asynchronous switch pins.
- btn_in  input  4  raw asynchronous button pins, 1 = pressed.
- peripheral_out  output  32  status word.
- irq  output  1  level interrupt request.

Behaviour:
- Reset (async) clears all sync flops, debounce counters, debounced values and pending flags. Outputs during and after reset: peripheral_out = 0, irq = 0.
- Synchronizer: each of the 12 raw bits passes through 2 flops (s1, s2).
- Debounce, per bit, operating on the synchronized value s2 and debounced value db:
  - s2 == db: counter cleared to 0.
  - s2 != db and counter < DB_CYCLES-1: counter increments.
  - s2 != db and counter == DB_CYCLES-1: db <= s2 and counter <= 0.
  - Any glitch shorter than DB_CYCLES clocks resets the count; db never toggles on it.
  - Latency from a stable raw change to db is 2 + DB_CYCLES negedges.
- Button edge: a db 0->1 transition on button i sets pending[i] on that same edge. 1->0 transitions set nothing.
- Read-to-clear: when GPIOfffffe00_re = 1 at a negedge, pending bits that were 1 before that edge are cleared.
- Read and new press on the same edge: the set wins and the bit remains 1, so a press is never lost.
- Read with no pending bits: no effect. Multiple consecutive read cycles each clear; no side effects beyond that.
- peripheral_out is combinational from registers and always valid; no read latency. Layout:
  - [7:0] switch db values.
  - [11:8] button db levels.
  - [15:12] pending[3:0].
  - [31:16] 0.
- irq = IRQ_EN & |pending; deasserts on the edge that clears the last pending bit.
- Reset mid-debounce discards the partial count; the input must re-qualify for the full DB_CYCLES after reset releases.

Decomposition:
- Shared io package:
  - Address constant 0xfffffe00.
  - Status-word field offsets: SW_LSB=0, BTN_LSB=8, PEND_LSB=12.
  - Default DB_CYCLES.
- Sub-module debounce_bit (params DB_CYCLES, DB_W; ports clk, reset, raw, db):
  - Contains the 2-flop synchronizer and counter for one bit.
  - Instantiated 12 times via generate.
  - Top level holds edge detect, pending logic, status mux and irq.

Test Plan (bench uses DB_CYCLES=4, DB_W=3):
1. Reset release with sw_in=8'hA5 held steady -> peripheral_out=0 until negedge 6; peripheral_out=32'h000000A5 from then on; irq=0 throughout.
2. btn_in[2] pulsed high for 3 clocks only -> no db change; peripheral_out[11:8]=0, pending=0, irq=0.
3. btn_in[0] held high 10 clocks -> bit8=1 and bit12=1 on the same edge, irq=1. Release, then one-cycle read strobe -> bit12 cleared, irq=0, bit8 follows the debounced release.
4. btn_in[1] debounced press lands on the same edge as a read strobe while pending[0]=1 -> after the edge pending=4'b0010 (bit0 cleared, bit1 kept), irq stays 1.
5. Assert reset while sw_in[3] has counted 2 of 4 -> after release, sw bit3 appears only after 2+4 further negedges; all pending bits 0.
6. IRQ_EN=0 with button presses applied -> pending bits behave as in scenario 3, irq stays 0.
